// File: rtl/spi_regfile_responder_pkg.sv
// Shared types and constants for the SPI register-file responder.
// Frame layout: one command byte followed by the data phase.
package spi_pkg;

    localparam int CMD_W      = 8;
    localparam int CMD_RW_BIT = 7;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        DONE
    } state_e;

    function automatic int FRAME_LEN(input int data_w);
        return CMD_W + data_w;
    endfunction

endpackage

// File: rtl/spi_regfile_responder_if.sv
// SPI pins plus local register port and commit/error notifications.
// master = bus owner / local logic side, slave = responder side.
interface spi_regfile_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              spi_clk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic              loc_we;
    logic [ADDR_W-1:0] loc_addr;
    logic [DATA_W-1:0] loc_wdata;
    logic [DATA_W-1:0] loc_rdata;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              err;

    modport master (
        output spi_clk, cs_n, mosi, loc_we, loc_addr, loc_wdata,
        input  miso, miso_oe, loc_rdata, wr_valid, wr_addr, wr_data, err
    );

    modport slave (
        input  spi_clk, cs_n, mosi, loc_we, loc_addr, loc_wdata,
        output miso, miso_oe, loc_rdata, wr_valid, wr_addr, wr_data, err
    );

endinterface

// File: rtl/spi_regfile_responder_sync.sv
// Two-flop synchronisers for the SPI pins and spi_clk edge pulses.
// spi_clk and mosi share latency, so mosi_o is aligned with rise_o.
module spi_in_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic spi_clk_i,
    input  logic cs_n_i,
    input  logic mosi_i,
    output logic cs_n_o,
    output logic mosi_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] clk_q;
    logic [1:0] cs_q;
    logic [1:0] mosi_q;
    logic       clk_prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_q      <= '0;
            cs_q       <= '1;
            mosi_q     <= '0;
            clk_prev_q <= 1'b0;
        end else begin
            clk_q      <= {clk_q[0], spi_clk_i};
            cs_q       <= {cs_q[0], cs_n_i};
            mosi_q     <= {mosi_q[0], mosi_i};
            clk_prev_q <= clk_q[1];
        end
    end

    assign cs_n_o = cs_q[1];
    assign mosi_o = mosi_q[1];
    assign rise_o = clk_q[1] & ~clk_prev_q;
    assign fall_o = ~clk_q[1] & clk_prev_q;

endmodule

// File: rtl/spi_regfile_responder.sv
// SPI mode-0 responder backed by a register file with a local port.
// Decodes cmd+data frames, commits writes and serves reads on miso.
module spi_regfile_responder
    import spi_pkg::*;
#(
    parameter int              DATA_W    = 32,
    parameter int              ADDR_W    = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic SCLK,
    input  logic SRESET,
    spi_regfile_responder_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int FL    = FRAME_LEN(DATA_W);
    localparam int CNT_W = $clog2(FL + 1);

    logic cs_n_s, mosi_s, rise, fall;

    spi_in_sync u_sync (
        .clk_i     (SCLK),
        .rst_i     (SRESET),
        .spi_clk_i (bus.spi_clk),
        .cs_n_i    (bus.cs_n),
        .mosi_i    (bus.mosi),
        .cs_n_o    (cs_n_s),
        .mosi_o    (mosi_s),
        .rise_o    (rise),
        .fall_o    (fall)
    );

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic              oor_q, oor_d;
    logic              miso_q, miso_d;
    logic              commit_q, commit_d;
    logic              err_q, err_d;
    logic              wv_q, wv_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;

    logic [DATA_W-1:0] regs_q [DEPTH];

    logic [CMD_W-1:0]      cmd_nxt;
    logic [CMD_RW_BIT-1:0] cmd_addr;
    logic                  cmd_oor;
    logic                  commit_wr;

    assign cmd_nxt   = {cmd_q[CMD_W-2:0], mosi_s};
    assign cmd_addr  = cmd_nxt[CMD_RW_BIT-1:0];
    assign cmd_oor   = |(cmd_addr >> ADDR_W);
    assign commit_wr = commit_q & ~oor_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        oor_d    = oor_q;
        miso_d   = miso_q;
        commit_d = 1'b0;
        err_d    = 1'b0;
        wv_d     = 1'b0;
        wa_d     = wa_q;
        wd_d     = wd_q;
        unique case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                cnt_d  = '0;
                if (!cs_n_s) state_d = CMD;
            end
            CMD: begin
                if (cs_n_s) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (rise) begin
                    cmd_d = cmd_nxt;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(CMD_W - 1)) begin
                        wr_d    = cmd_nxt[CMD_RW_BIT];
                        addr_d  = cmd_nxt[ADDR_W-1:0];
                        oor_d   = cmd_oor;
                        // Snapshot taken before any same-edge register write lands
                        tx_d    = cmd_oor ? '0 : regs_q[cmd_nxt[ADDR_W-1:0]];
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (cs_n_s) begin
                    err_d   = 1'b1;
                    miso_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (fall && !wr_q) begin
                        miso_d = tx_q[DATA_W-1];
                        tx_d   = tx_q << 1;
                    end
                    if (rise) begin
                        rx_d  = {rx_q[DATA_W-2:0], mosi_s};
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(FL - 1)) begin
                            commit_d = wr_q;
                            miso_d   = 1'b0;
                            state_d  = DONE;
                        end
                    end
                end
            end
            DONE: begin
                miso_d = 1'b0;
                if (cs_n_s) begin
                    err_d   = ~wr_q & oor_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit_q) begin
            err_d = err_d | oor_q;
            wv_d  = ~oor_q;
            if (!oor_q) begin
                wa_d = addr_q;
                wd_d = rx_q;
            end
        end
    end

    always_ff @(posedge SCLK or posedge SRESET) begin
        if (SRESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cmd_q    <= '0;
            rx_q     <= '0;
            tx_q     <= '0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            oor_q    <= 1'b0;
            miso_q   <= 1'b0;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
            wv_q     <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            oor_q    <= oor_d;
            miso_q   <= miso_d;
            commit_q <= commit_d;
            err_q    <= err_d;
            wv_q     <= wv_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
        end
    end

    // SPI commit beats a local write to the same index
    always_ff @(posedge SCLK or posedge SRESET) begin
        if (SRESET) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= RESET_VAL;
        end else begin
            if (bus.loc_we && !(commit_wr && addr_q == bus.loc_addr))
                regs_q[bus.loc_addr] <= bus.loc_wdata;
            if (commit_wr)
                regs_q[addr_q] <= rx_q;
        end
    end

    assign bus.miso      = miso_q;
    assign bus.miso_oe   = ~cs_n_s;
    assign bus.loc_rdata = regs_q[bus.loc_addr];
    assign bus.wr_valid  = wv_q;
    assign bus.wr_addr   = wa_q;
    assign bus.wr_data   = wd_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_spi_regfile_responder.sv
// Bench for spi_regfile_responder: SPI master model plus register-file
// reference array; directed scenarios followed by randomized frames.
module tb_spi_regfile_responder;

    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int HALF = 8;

    logic SCLK = 1'b0;
    logic SRESET = 1'b1;

    always #5 SCLK = ~SCLK;

    spi_regfile_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    spi_regfile_responder #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .RESET_VAL ('0)
    ) dut (
        .SCLK   (SCLK),
        .SRESET (SRESET),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int wv_cnt = 0;
    int err_cnt = 0;
    logic [AW-1:0] last_wa = '0;
    logic [DW-1:0] last_wd = '0;
    logic [DW-1:0] model [16];

    always @(negedge SCLK) begin
        if (bus.wr_valid === 1'b1) begin
            wv_cnt++;
            last_wa = bus.wr_addr;
            last_wd = bus.wr_data;
        end
        if (bus.err === 1'b1) err_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge SCLK);
    endtask

    task automatic loc_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge SCLK);
        bus.loc_we = 1'b1;
        bus.loc_addr = a;
        bus.loc_wdata = d;
        @(negedge SCLK);
        bus.loc_we = 1'b0;
        model[a] = d;
    endtask

    task automatic loc_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        @(negedge SCLK);
        bus.loc_addr = a;
        #1;
        d = bus.loc_rdata;
    endtask

    // Full or truncated SPI frame; optional local write at a chosen cycle
    // after the final rising edge, optional reset in place of cs_n release.
    task automatic xfer(input logic [7:0] cmd, input logic [DW-1:0] data,
                        input int nbits, input int coll_at,
                        input logic [DW-1:0] coll_data, input bit rst_mid,
                        output logic [DW-1:0] rd, output int lat);
        logic [8+DW-1:0] fr;
        int total;
        fr = {cmd, data};
        total = 8 + nbits;
        rd = '0;
        lat = -1;
        bus.cs_n = 1'b0;
        cyc(4);
        for (int b = 0; b < total; b++) begin
            bus.mosi = fr[8+DW-1-b];
            cyc(HALF);
            if (b == 0) begin
                checks++;
                if (bus.miso_oe !== 1'b1) begin
                    errors++;
                    $display("FAIL miso_oe_sel: got %b want 1", bus.miso_oe);
                end
            end
            if (b >= 8) rd = {rd[DW-2:0], bus.miso};
            bus.spi_clk = 1'b1;
            if (b == 8 + DW - 1) begin
                for (int i = 1; i <= HALF; i++) begin
                    @(negedge SCLK);
                    if (bus.wr_valid === 1'b1 && lat < 0) lat = i;
                    bus.loc_we = (i == coll_at);
                    if (i == coll_at) begin
                        bus.loc_addr = cmd[AW-1:0];
                        bus.loc_wdata = coll_data;
                    end
                end
                bus.loc_we = 1'b0;
            end else begin
                cyc(HALF);
            end
            bus.spi_clk = 1'b0;
        end
        if (rst_mid) begin
            cyc(3);
            SRESET = 1'b1;
            bus.cs_n = 1'b1;
            bus.mosi = 1'b0;
            cyc(4);
            checks++;
            if ({bus.miso, bus.miso_oe, bus.wr_valid, bus.err} !== 4'b0 ||
                bus.wr_addr !== '0 || bus.wr_data !== '0) begin
                errors++;
                $display("FAIL rst_mid_outs: got %b/%h/%h want 0",
                         {bus.miso, bus.miso_oe, bus.wr_valid, bus.err},
                         bus.wr_addr, bus.wr_data);
            end
            SRESET = 1'b0;
            cyc(2);
        end else begin
            cyc(HALF);
            bus.cs_n = 1'b1;
            bus.mosi = 1'b0;
            cyc(8);
            checks++;
            if (bus.miso_oe !== 1'b0) begin
                errors++;
                $display("FAIL miso_oe_idle: got %b want 0", bus.miso_oe);
            end
        end
    endtask

    // Full frame checked against the model: read data, commit and err pulses
    task automatic frame_check(input string name, input logic [7:0] cmd,
                               input logic [DW-1:0] data);
        logic [DW-1:0] rd, exp_rd;
        int lat, wv0, er0, exp_wv, exp_er;
        logic oor;
        logic [AW-1:0] a;
        oor = (cmd[6:AW] != '0);
        a = cmd[AW-1:0];
        exp_rd = oor ? '0 : model[a];
        wv0 = wv_cnt;
        er0 = err_cnt;
        xfer(cmd, data, DW, -1, '0, 1'b0, rd, lat);
        exp_er = oor ? 1 : 0;
        exp_wv = (cmd[7] && !oor) ? 1 : 0;
        if (!cmd[7]) begin
            checks++;
            if (rd !== exp_rd) begin
                errors++;
                $display("FAIL %s_rdata: got %h want %h", name, rd, exp_rd);
            end
        end
        checks++;
        if (wv_cnt - wv0 !== exp_wv || err_cnt - er0 !== exp_er) begin
            errors++;
            $display("FAIL %s_pulses: got wv=%0d err=%0d want wv=%0d err=%0d",
                     name, wv_cnt - wv0, err_cnt - er0, exp_wv, exp_er);
        end
        if (exp_wv == 1) begin
            model[a] = data;
            checks++;
            if (last_wa !== a || last_wd !== data) begin
                errors++;
                $display("FAIL %s_commit: got %h/%h want %h/%h",
                         name, last_wa, last_wd, a, data);
            end
        end
    endtask

    task automatic check_all_regs(input string name);
        logic [DW-1:0] d;
        for (int i = 0; i < 16; i++) begin
            loc_read(AW'(i), d);
            checks++;
            if (d !== model[i]) begin
                errors++;
                $display("FAIL %s_reg%0d: got %h want %h", name, i, d, model[i]);
            end
        end
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        cyc(3);
        checks++;
        if ({bus.miso, bus.miso_oe, bus.wr_valid, bus.err} !== 4'b0 ||
            bus.wr_addr !== '0 || bus.wr_data !== '0) begin
            errors++;
            $display("FAIL reset_outs: got %b/%h/%h want 0",
                     {bus.miso, bus.miso_oe, bus.wr_valid, bus.err},
                     bus.wr_addr, bus.wr_data);
        end
        SRESET = 1'b0;
        cyc(3);
        loc_read(4'd9, d);
        checks++;
        if (d !== '0) begin
            errors++;
            $display("FAIL reset_reg9: got %h want 0", d);
        end
        frame_check("reset_read", 8'h03, $urandom);
    endtask

    task automatic test_write();
        logic [DW-1:0] d;
        frame_check("write", 8'h85, 32'hDEADBEEF);
        loc_read(4'd5, d);
        checks++;
        if (d !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_loc: got %h want deadbeef", d);
        end
    endtask

    task automatic test_read();
        frame_check("read", 8'h05, $urandom);
    endtask

    task automatic test_abort();
        logic [DW-1:0] rd, d;
        int lat, wv0, er0;
        wv0 = wv_cnt;
        er0 = err_cnt;
        xfer(8'h82, $urandom, 12, -1, '0, 1'b0, rd, lat);
        checks++;
        if (wv_cnt != wv0 || err_cnt - er0 != 1) begin
            errors++;
            $display("FAIL abort_pulses: got wv=%0d err=%0d want 0/1",
                     wv_cnt - wv0, err_cnt - er0);
        end
        loc_read(4'd2, d);
        checks++;
        if (d !== model[2]) begin
            errors++;
            $display("FAIL abort_reg2: got %h want %h", d, model[2]);
        end
    endtask

    task automatic test_range();
        frame_check("range_wr", 8'hF0, 32'h12345678);
        frame_check("range_rd", 8'h70, $urandom);
        check_all_regs("range");
    endtask

    task automatic test_collision();
        logic [DW-1:0] rd, d;
        int lat, lat2;
        xfer(8'h85, 32'h12345678, DW, -1, '0, 1'b0, rd, lat);
        model[5] = 32'h12345678;
        checks++;
        if (lat < 2) begin
            errors++;
            $display("FAIL coll_calib: got lat=%0d want >=2", lat);
            lat = 2;
        end
        // Local write sampled on the same edge as the commit
        xfer(8'h85, 32'hCAFEF00D, DW, lat - 1, 32'h11111111, 1'b0, rd, lat2);
        model[5] = 32'hCAFEF00D;
        loc_read(4'd5, d);
        checks++;
        if (d !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL coll_same: got %h want cafef00d", d);
        end
        // One cycle later the local write lands after the commit
        xfer(8'h85, 32'h0BADF00D, DW, lat, 32'h11111111, 1'b0, rd, lat2);
        model[5] = 32'h11111111;
        loc_read(4'd5, d);
        checks++;
        if (d !== 32'h11111111) begin
            errors++;
            $display("FAIL coll_after: got %h want 11111111", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] rd;
        int lat, er0, wv0;
        er0 = err_cnt;
        wv0 = wv_cnt;
        xfer(8'h85, $urandom, 10, -1, '0, 1'b1, rd, lat);
        for (int i = 0; i < 16; i++) model[i] = '0;
        checks++;
        if (err_cnt != er0 || wv_cnt != wv0) begin
            errors++;
            $display("FAIL rst_mid_pulses: got err=%0d wv=%0d want 0/0",
                     err_cnt - er0, wv_cnt - wv0);
        end
        check_all_regs("rst_mid");
        frame_check("post_rst_wr", 8'h83, 32'hAABBCCDD);
        frame_check("post_rst_rd", 8'h03, $urandom);
    endtask

    task automatic test_random();
        logic [7:0] cmd;
        logic [2:0] hi;
        for (int n = 0; n < 24; n++) begin
            hi = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            cmd = {1'($urandom_range(0, 1)), hi, 4'($urandom_range(0, 15))};
            if ($urandom_range(0, 3) == 0)
                loc_write(4'($urandom_range(0, 15)), $urandom);
            frame_check("rand", cmd, $urandom);
        end
        check_all_regs("rand");
    endtask

    initial begin
        bus.spi_clk = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        bus.loc_we = 1'b0;
        bus.loc_addr = '0;
        bus.loc_wdata = '0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_range();
        test_collision();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
